// File: rtl/cursor_select_ctrl.sv
// Cursor and two-pick tile selection controller for the lianliankan board.
// Buttons are synchronized and edge-detected. Direction presses move the cursor
// with hold-to-repeat. Select presses drive a three-state pick FSM that hands
// completed pairs to the match logic over a valid/ready handshake.
module cursor_select_ctrl #(
  parameter int COLS         = 10,
  parameter int ROWS         = 8,
  parameter int X_W          = 4,
  parameter int Y_W          = 3,
  parameter int TICK_DIV     = 100000,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           up,
  input  logic           right,
  input  logic           down,
  input  logic           left,
  input  logic           s,
  input  logic           cell_occupied,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic           sel_valid,
  output logic [X_W-1:0] sel_x,
  output logic [Y_W-1:0] sel_y,
  output logic           req_valid,
  output logic [X_W-1:0] req_x0,
  output logic [Y_W-1:0] req_y0,
  output logic [X_W-1:0] req_x1,
  output logic [Y_W-1:0] req_y1,
  input  logic           req_ready
);

  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // Bit positions in the button vector; direction indices double as move codes.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;
  localparam int         BTN_S     = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_REQ} state_t;

  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [4:0] press;

  logic [X_W-1:0]     cur_x_q, cur_x_d;
  logic [Y_W-1:0]     cur_y_q, cur_y_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc, hold_limit;
  logic               rep_first_q, rep_first_d;
  logic [1:0]         active_q, active_d;
  logic               active_vld_q, active_vld_d;
  logic               tick, move_vld;
  logic [1:0]         move_dir;
  logic [3:0]         dir_lvl;

  state_t         state_q, state_d;
  logic [X_W-1:0] sel_x_q, sel_x_d, req_x0_q, req_x0_d, req_x1_q, req_x1_d;
  logic [Y_W-1:0] sel_y_q, sel_y_d, req_y0_q, req_y0_d, req_y1_q, req_y1_d;
  logic           s_press, same_cell;

  assign btn_raw = {s, left, down, right, up};

  // Synchronizer chain and rising-edge detect; prev tracks sync2 even when disabled.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press   = sync2_q & ~prev_q;
    dir_lvl = sync2_q[3:0];
  end

  // Input registers; reset to all-ones so a button held through reset gives no press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Cursor move selection: fresh press wins, otherwise hold-to-repeat on the active direction.
  always_comb begin
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    presc_d      = presc_q;
    hold_d       = hold_q;
    rep_first_d  = rep_first_q;
    active_d     = active_q;
    active_vld_d = active_vld_q;
    move_vld     = 1'b0;
    move_dir     = DIR_UP;
    tick         = 1'b0;
    hold_inc     = hold_q + HOLD_W'(1);
    hold_limit   = rep_first_q ? HOLD_W'(REPEAT_DELAY) : HOLD_W'(REPEAT_RATE);
    if (en) begin
      tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      if (press[3:0] != 4'b0000) begin
        if (press[DIR_UP])         move_dir = DIR_UP;
        else if (press[DIR_RIGHT]) move_dir = DIR_RIGHT;
        else if (press[DIR_DOWN])  move_dir = DIR_DOWN;
        else                       move_dir = DIR_LEFT;
        move_vld     = 1'b1;
        active_d     = move_dir;
        active_vld_d = 1'b1;
        presc_d      = '0;
        hold_d       = '0;
        rep_first_d  = 1'b1;
      end else if (active_vld_q) begin
        if (!dir_lvl[active_q]) begin
          active_vld_d = 1'b0;
        end else if (tick) begin
          if (hold_inc == hold_limit) begin
            move_vld    = 1'b1;
            move_dir    = active_q;
            hold_d      = '0;
            rep_first_d = 1'b0;
          end else begin
            hold_d = hold_inc;
          end
        end
      end
    end
    if (move_vld) begin
      case (move_dir)
        DIR_UP:    cur_y_d = (cur_y_q == '0) ? Y_W'(ROWS - 1) : cur_y_q - Y_W'(1);
        DIR_DOWN:  cur_y_d = (cur_y_q == Y_W'(ROWS - 1)) ? '0 : cur_y_q + Y_W'(1);
        DIR_LEFT:  cur_x_d = (cur_x_q == '0) ? X_W'(COLS - 1) : cur_x_q - X_W'(1);
        default:   cur_x_d = (cur_x_q == X_W'(COLS - 1)) ? '0 : cur_x_q + X_W'(1);
      endcase
    end
  end

  // Cursor and repeat-timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      presc_q      <= '0;
      hold_q       <= '0;
      rep_first_q  <= 1'b1;
      active_q     <= DIR_UP;
      active_vld_q <= 1'b0;
    end else begin
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      rep_first_q  <= rep_first_d;
      active_q     <= active_d;
      active_vld_q <= active_vld_d;
    end
  end

  // Selection FSM state and pick/pair registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_x_q  <= '0;
      sel_y_q  <= '0;
      req_x0_q <= '0;
      req_y0_q <= '0;
      req_x1_q <= '0;
      req_y1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_x_q  <= sel_x_d;
      sel_y_q  <= sel_y_d;
      req_x0_q <= req_x0_d;
      req_y0_q <= req_y0_d;
      req_x1_q <= req_x1_d;
      req_y1_q <= req_y1_d;
    end
  end

  // Next-state logic; selection uses the pre-move cursor held in cur_*_q.
  always_comb begin
    state_d   = state_q;
    sel_x_d   = sel_x_q;
    sel_y_d   = sel_y_q;
    req_x0_d  = req_x0_q;
    req_y0_d  = req_y0_q;
    req_x1_d  = req_x1_q;
    req_y1_d  = req_y1_q;
    s_press   = en & press[BTN_S];
    same_cell = (cur_x_q == sel_x_q) && (cur_y_q == sel_y_q);
    case (state_q)
      ST_IDLE: begin
        if (s_press && cell_occupied) begin
          sel_x_d = cur_x_q;
          sel_y_d = cur_y_q;
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (s_press) begin
          if (same_cell) begin
            state_d = ST_IDLE;
          end else if (cell_occupied) begin
            req_x0_d = sel_x_q;
            req_y0_d = sel_y_q;
            req_x1_d = cur_x_q;
            req_y1_d = cur_y_q;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (req_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    cur_x     = cur_x_q;
    cur_y     = cur_y_q;
    sel_valid = (state_q == ST_FIRST);
    sel_x     = sel_x_q;
    sel_y     = sel_y_q;
    req_valid = (state_q == ST_REQ);
    req_x0    = req_x0_q;
    req_y0    = req_y0_q;
    req_x1    = req_x1_q;
    req_y1    = req_y1_q;
  end

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Directed bench for cursor_select_ctrl: wrap, auto-repeat timing, priority,
// held-at-reset, pair handshake, cancel/empty picks and enable gating.
module tb_cursor_select_ctrl;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int X_W  = 2;
  localparam int Y_W  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [4:0]     btn;
  logic           cell_occupied;
  logic           req_ready;
  logic [X_W-1:0] cur_x, sel_x, req_x0, req_x1;
  logic [Y_W-1:0] cur_y, sel_y, req_y0, req_y1;
  logic           sel_valid, req_valid;

  int checks = 0;
  int errors = 0;

  cursor_select_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W),
    .TICK_DIV(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .up(btn[0]), .right(btn[1]), .down(btn[2]), .left(btn[3]), .s(btn[4]),
    .cell_occupied(cell_occupied),
    .cur_x(cur_x), .cur_y(cur_y),
    .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y),
    .req_valid(req_valid),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_ready(req_ready)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, landing 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-22s observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-cycle button pulse; afterwards the resulting move/state change is visible.
  task automatic pulse(input int idx);
    btn[idx] = 1'b1;
    step(1);
    btn[idx] = 1'b0;
    step(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    en = 1'b1; btn = '0; cell_occupied = 1'b0; req_ready = 1'b0; rst = 1'b1;
    step(1);

    // Reset and wrap
    do_reset();
    chk("rst_cur_x", 32'(cur_x), 0);
    chk("rst_cur_y", 32'(cur_y), 0);
    chk("rst_sel_valid", 32'(sel_valid), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_req_x1", 32'(req_x1), 0);
    pulse(3);
    chk("wrap_left_x", 32'(cur_x), 3);
    pulse(0);
    chk("wrap_up_y", 32'(cur_y), 2);
    chk("wrap_x_kept", 32'(cur_x), 3);
    chk("wrap_sel_valid", 32'(sel_valid), 0);
    chk("wrap_req_valid", 32'(req_valid), 0);

    // Auto-repeat: right held from (0,0)
    do_reset();
    btn[1] = 1'b1;
    step(2);
    chk("rep_before_P", 32'(cur_x), 0);
    step(1);                       // edge P
    chk("rep_P", 32'(cur_x), 1);
    step(11);                      // P+11
    chk("rep_P11", 32'(cur_x), 1);
    step(1);                       // P+12
    chk("rep_P12", 32'(cur_x), 2);
    step(7);                       // P+19
    chk("rep_P19", 32'(cur_x), 2);
    step(1);                       // P+20
    chk("rep_P20", 32'(cur_x), 3);
    step(8);                       // P+28
    chk("rep_P28", 32'(cur_x), 0);
    step(2);                       // P+30: release
    btn[1] = 1'b0;
    step(6);                       // P+36
    chk("rep_released_P36", 32'(cur_x), 0);
    step(8);
    chk("rep_released_P44", 32'(cur_x), 0);

    // Priority and held-through-reset
    btn = 5'b00001;                // up held across reset
    do_reset();
    step(4);
    chk("held_rst_y", 32'(cur_y), 0);
    btn[3] = 1'b1;
    btn[2] = 1'b1;
    step(1);
    btn = '0;
    step(2);
    chk("prio_down_y", 32'(cur_y), 1);
    chk("prio_x", 32'(cur_x), 0);

    // Pair request
    do_reset();
    cell_occupied = 1'b1;
    pulse(4);
    chk("pair_sel_valid", 32'(sel_valid), 1);
    chk("pair_sel_x", 32'(sel_x), 0);
    pulse(1);
    chk("pair_cur_x", 32'(cur_x), 1);
    pulse(4);
    chk("pair_req_valid", 32'(req_valid), 1);
    chk("pair_sel_cleared", 32'(sel_valid), 0);
    chk("pair_req", {req_x0, req_y0, req_x1, req_y1}, {2'd0, 2'd0, 2'd1, 2'd0});
    step(5);
    chk("pair_hold_valid", 32'(req_valid), 1);
    chk("pair_hold_req", {req_x0, req_y0, req_x1, req_y1}, {2'd0, 2'd0, 2'd1, 2'd0});
    req_ready = 1'b1;
    step(1);
    req_ready = 1'b0;
    chk("pair_accepted", 32'(req_valid), 0);
    chk("pair_idle_sel", 32'(sel_valid), 0);

    // Cancel and empty cells (cursor at (1,0), IDLE)
    cell_occupied = 1'b0;
    pulse(4);
    chk("empty_idle", 32'(sel_valid), 0);
    pulse(1);
    pulse(2);
    chk("move_to_21", {cur_x, cur_y}, {2'd2, 2'd1});
    cell_occupied = 1'b1;
    pulse(4);
    chk("sel_21_valid", 32'(sel_valid), 1);
    chk("sel_21", {sel_x, sel_y}, {2'd2, 2'd1});
    pulse(4);
    chk("cancel_same", 32'(sel_valid), 0);
    chk("cancel_no_req", 32'(req_valid), 0);
    pulse(4);
    chk("reselect_21", 32'(sel_valid), 1);
    pulse(1);
    cell_occupied = 1'b0;
    pulse(4);
    chk("first_empty_sel", 32'(sel_valid), 1);
    chk("first_empty_req", 32'(req_valid), 0);
    chk("first_empty_selx", 32'(sel_x), 2);

    // Enable gating (cursor (3,1), FIRST with pick (2,1))
    en = 1'b0;
    cell_occupied = 1'b1;
    pulse(1);
    chk("en0_right", 32'(cur_x), 3);
    pulse(4);
    chk("en0_s_req", 32'(req_valid), 0);
    chk("en0_s_sel", 32'(sel_valid), 1);
    btn[1] = 1'b1;
    step(4);
    en = 1'b1;
    step(5);
    chk("en_held_right", 32'(cur_x), 3);
    btn[1] = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cursor_select_ctrl.md
# cursor_select_ctrl

Cursor and tile-selection controller for the lianliankan board. Consumes the five debounced button levels (up/right/down/left/select) and turns them into single-step cursor moves with hold-to-repeat. Runs a two-pick selection state machine and hands each completed tile pair to the match-checking logic over a valid/ready handshake. Sits between the button debounce stage and the game-board logic.

## Interface

**Parameters**

- `COLS`, default 10: board width in cells.
- `ROWS`, default 8: board height in cells.
- `X_W`, default 4: width of x coordinates; must satisfy 2^X_W ≥ COLS.
- `Y_W`, default 3: width of y coordinates; must satisfy 2^Y_W ≥ ROWS.
- `TICK_DIV`, default 100000: clk cycles per repeat tick (1 kHz at 100 MHz).
- `REPEAT_DELAY`, default 400: ticks a direction is held before the first auto-repeat.
- `REPEAT_RATE`, default 100: ticks between subsequent auto-repeats.

**Ports**

- `clk` in 1: system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enables cursor movement and selection.
- `up`, `right`, `down`, `left`, `s` in 1 each: debounced button levels, asynchronous to `clk`.
- `cell_occupied` in 1: combinational from the board; 1 when the cell at (`cur_x`, `cur_y`) holds a tile.
- `cur_x` out X_W: cursor column.
- `cur_y` out Y_W: cursor row.
- `sel_valid` out 1: a first tile is currently picked.
- `sel_x` out X_W, `sel_y` out Y_W: coordinates of the first pick.
- `req_valid` out 1: a pair request is pending.
- `req_x0` out X_W, `req_y0` out Y_W: first tile of the pair.
- `req_x1` out X_W, `req_y1` out Y_W: second tile of the pair.
- `req_ready` in 1: match logic accepts the request.

## Operation

**Input conditioning**
- Every button passes through a 2-flop synchronizer.
- A `prev` register holds the last synchronized level; press = sync & ~prev.
- `prev` updates every cycle regardless of `en`, so a press occurring while `en` is low is lost, not deferred.
- `prev` resets to all-ones, so a button held through reset produces no press.

**Cursor**
- Only one move is applied per cycle. Priority: up > right > down > left.
- up decrements `cur_y`; down increments it. left decrements `cur_x`; right increments it.
- Wrap-around: right from COLS-1 → 0, left from 0 → COLS-1. Rows wrap the same way using ROWS.

**Auto-repeat**
- The active direction is the highest-priority direction press.
- A press restarts the prescaler and clears the hold counter.
- The prescaler emits one tick every TICK_DIV cycles while `en` is high.
- While the active direction stays held, the hold counter counts ticks:
  - First repeat move at REPEAT_DELAY ticks.
  - Further repeat moves every REPEAT_RATE ticks after that.
- Releasing the active direction stops repeat; no repeat fires while it is released.
- A new press of any direction takes over as the active direction.
- Holding `s` never repeats.

**Selection FSM**
- States: IDLE, FIRST, REQ.
- IDLE:
  - `s` press with `cell_occupied`=1 → latch `sel_x`/`sel_y` from the cursor, `sel_valid`=1, go to FIRST.
  - `s` press on an empty cell is ignored.
- FIRST:
  - `s` press on the same cell → `sel_valid`=0, go to IDLE (cancel).
  - `s` press on a different occupied cell → load `req_*0` from `sel_*` and `req_*1` from the cursor, `req_valid`=1, `sel_valid`=0, go to REQ.
  - `s` press on an empty cell is ignored.
- REQ:
  - `req_*` are held stable while `req_valid`=1.
  - On the cycle `req_valid` & `req_ready` are both high, the request is accepted; the next cycle `req_valid`=0 and the state is IDLE.
  - `s` presses are ignored. Cursor moves remain allowed.
- `en`=0 freezes the cursor, repeat counters, prescaler and the IDLE/FIRST transitions. The REQ handshake still completes.
- If a move and an `s` press occur in the same cycle, selection uses the pre-move cursor.

## Timing

- Reset values: `cur_x`=0, `cur_y`=0, `sel_valid`=0, `sel_x`/`sel_y`=0, `req_valid`=0, all `req_*`=0, FSM=IDLE, hold counter and prescaler=0.
- A button level rising before edge k moves the cursor (or changes FSM state) at edge k+2, visible from cycle k+2. That is 2 synchronizer stages plus 1 update register.
- `req_valid` rises at the same edge as the FIRST→REQ transition.
- `cell_occupied` is sampled in the same cycle as the `s` press.
- Reset mid-REQ drops the request with no handshake completion.
- The first repeat occurs exactly REPEAT_DELAY×TICK_DIV cycles after the press-induced move. Each later repeat follows REPEAT_RATE×TICK_DIV cycles after the previous one.

## Test plan

Use COLS=4, ROWS=3, TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2 unless noted.

- **Reset and wrap:** after reset, pulse left once, then up once → `cur_x`=3 then `cur_y`=2. All other outputs stay at their reset values.
- **Auto-repeat:** hold right from cursor (0,0). The press moves to x=1 at cycle P. Further moves to x=2, 3, 0 at P+12, P+20, P+28. Release at P+30 → no move at P+36.
- **Priority and held-at-reset:** hold up through reset release → no move. Then press left and down in the same cycle → only down applies, `cur_y`=1.
- **Pair request:** select at (0,0) with occupied=1 → `sel_valid`=1. Move right, select at (1,0) with occupied=1 → `req_valid`=1, req=(0,0)/(1,0). Hold `req_ready`=0 for 5 cycles → outputs stable. Pulse `req_ready` → IDLE next cycle.
- **Cancel and empty:**
  - `s` on an empty cell → stays IDLE.
  - Select (2,1), then `s` again on (2,1) → `sel_valid`=0.
  - In FIRST, `s` on an empty cell → stays in FIRST.
- **Enable gating:** with `en`=0, pulses on right and `s` → no change. A right press made while `en`=0 and held until `en` returns high → no move.
